// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding and SRAM bus geometry.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD       = 3'd1,
    S_WR_SETUP = 3'd2,
    S_WR_PULSE = 3'd3,
    S_WR_HOLD  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Async SRAM controller bridging a single-request CPU bus to registered SRAM strobes.
// Optional macro SRAM_CTRL_BYTE_EN enables byte-lane writes from the latched select.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_ce_i,
  input  logic               req_we_i,
  input  logic [31:0]        req_addr_i,
  input  logic [3:0]         req_sel_i,
  input  logic [31:0]        req_data_i,
  output logic [31:0]        rsp_data_o,
  output logic               rsp_ack_o,
  output logic               stall_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  inout  wire  [SRAM_DW-1:0] sram_data_io,
  output logic [3:0]         sram_be_n_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output state_t             dbg_state_o
);

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_t             r_state;
  logic [2:0]         r_wait;
  logic [SRAM_AW-1:0] r_addr;
  logic [SRAM_DW-1:0] r_wdata;
  logic [SRAM_DW-1:0] r_rdata;
  logic [3:0]         r_be_n;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_bus_oe;
  logic               r_ack;

  // Unused address bits alias; select only matters when byte enables are built in.
`ifdef SRAM_CTRL_BYTE_EN
  logic w_unused;
  assign w_unused = ^{req_addr_i[31:22], req_addr_i[1:0]};
`else
  logic w_unused;
  assign w_unused = ^{req_addr_i[31:22], req_addr_i[1:0], req_sel_i};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wait   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_be_n   <= 4'hF;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_bus_oe <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= 1'b0;
`ifndef SRAM_CTRL_BYTE_EN
      r_be_n <= 4'h0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req_ce_i) begin
            r_addr  <= req_addr_i[21:2];
            r_wdata <= req_data_i;
            r_ce_n  <= 1'b0;
            r_wait  <= '0;
`ifdef SRAM_CTRL_BYTE_EN
            r_be_n  <= req_we_i ? ~req_sel_i : 4'h0;
`endif
            if (req_we_i) begin
              r_state  <= S_WR_SETUP;
              r_bus_oe <= 1'b1;
            end else begin
              r_state <= S_RD;
              r_oe_n  <= 1'b0;
            end
          end
        end
        S_RD: begin
          // Data is captured on the edge that closes the read window.
          if (r_wait == WAIT_LAST) begin
            r_rdata <= sram_data_io;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_wait  <= '0;
          r_state <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (r_wait == WAIT_LAST) begin
            r_we_n  <= 1'b1;
            r_state <= S_WR_HOLD;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_WR_HOLD: begin
          r_bus_oe <= 1'b0;
          r_ce_n   <= 1'b1;
          r_ack    <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sram_data_io = r_bus_oe ? r_wdata : 'z;

  assign sram_addr_o = r_addr;
  assign sram_be_n_o = r_be_n;
  assign sram_ce_n_o = r_ce_n;
  assign sram_oe_n_o = r_oe_n;
  assign sram_we_n_o = r_we_n;
  assign rsp_data_o  = r_rdata;
  assign rsp_ack_o   = r_ack;
  assign stall_o     = req_ce_i & (r_state != S_DONE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table, SRAM model, scoreboard and corner sequences.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ce_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [3:0]  req_sel_i = '0;
  logic [31:0] req_data_i = '0;
  logic [31:0] rsp_data_o;
  logic        rsp_ack_o;
  logic        stall_o;
  logic [19:0] sram_addr_o;
  wire  [31:0] sram_data_io;
  logic [3:0]  sram_be_n_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  state_t      dbg_state;

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_ce_i(req_ce_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_sel_i(req_sel_i), .req_data_i(req_data_i),
    .rsp_data_o(rsp_data_o), .rsp_ack_o(rsp_ack_o), .stall_o(stall_o),
    .sram_addr_o(sram_addr_o), .sram_data_io(sram_data_io), .sram_be_n_o(sram_be_n_o),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // SRAM model (256 words, aliased on low address bits)
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];

  assign sram_data_io = (!sram_ce_n_o && !sram_oe_n_o && sram_we_n_o) ? mem[sram_addr_o[7:0]] : 'z;

  always @(posedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n_o[b]) mem[sram_addr_o[7:0]][8*b +: 8] <= sram_data_io[8*b +: 8];
  end

  // Checking helpers
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] exp_last_rd = '0;
  logic [31:0] sb_exp;

  always @(negedge clk) begin
    if (rst_n && rsp_ack_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        check("rsp_data", rsp_data_o, sb_exp);
      end
    end
  end

  task automatic push_expect(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] data);
    logic [7:0] idx;
    idx = addr[9:2];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
`ifdef SRAM_CTRL_BYTE_EN
        if (sel[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
`else
        ref_mem[idx][8*b +: 8] = data[8*b +: 8];
`endif
      end
    end else begin
      exp_last_rd = ref_mem[idx];
    end
    exp_q.push_back(exp_last_rd);
  endtask

  // Vector table
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic        keep_ce;
    logic [19:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs [0:9];

  task automatic run_txn(input vec_t v);
    int lat, we_lo, oe_lo, drv, ovl, stall_bad;
    logic seen_ack;
    logic [3:0] exp_be;
    logic stall_exp;
`ifdef SRAM_CTRL_BYTE_EN
    exp_be = v.we ? ~v.sel : 4'h0;
`else
    exp_be = 4'h0;
`endif
    push_expect(v.we, v.addr, v.sel, v.data);
    @(negedge clk);
    req_ce_i = 1'b1; req_we_i = v.we; req_addr_i = v.addr;
    req_sel_i = v.sel; req_data_i = v.data;
    @(posedge clk);
    #1;
    // Scramble request fields: the latched copy must be used
    req_ce_i = v.keep_ce; req_we_i = ~v.we; req_addr_i = $urandom;
    req_sel_i = 4'($urandom_range(0, 15)); req_data_i = $urandom;
    lat = 0; we_lo = 0; oe_lo = 0; drv = 0; ovl = 0; stall_bad = 0; seen_ack = 1'b0;
    while (!seen_ack && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("sram_addr", 32'(sram_addr_o), 32'(v.exp_addr));
        check("be_n", 32'(sram_be_n_o), 32'(exp_be));
      end
      if (!sram_we_n_o) we_lo++;
      if (!sram_oe_n_o) oe_lo++;
      if (dbg_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD}) begin
        drv++;
        if (!sram_oe_n_o) ovl++;
      end
      stall_exp = v.keep_ce && (lat != v.exp_lat);
      if (stall_o !== stall_exp) stall_bad++;
      if (rsp_ack_o) seen_ack = 1'b1;
    end
    req_ce_i = 1'b0;
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("we_n_low_cycles", 32'(we_lo), v.we ? 32'(W + 1) : 32'd0);
    check("oe_n_low_cycles", 32'(oe_lo), v.we ? 32'd0 : 32'(W + 1));
    check("bus_drive_cycles", 32'(drv), v.we ? 32'(W + 3) : 32'd0);
    check("oe_drive_overlap", 32'(ovl), 32'd0);
    check("stall_pattern", 32'(stall_bad), 32'd0);
  endtask

  // Main test
  initial begin
    int cyc, acks, last_ack, gap_bad, stall_bad, ovl, n, we_lo, ce_lo;
    logic prev_ce_n;
    vec_t b2b [0:2];

    for (int i = 0; i < 256; i++) begin
      mem[i] = {8'(i), 8'hA5, 8'(~i), 8'h5A};
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    //          we    addr           sel      data          keep  exp_addr   lat
    vecs[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         1'b1, 20'h00004, W + 2};
    vecs[1] = '{1'b1, 32'h0000_0020, 4'hF, 32'h12345678,  1'b0, 20'h00008, W + 4};
    vecs[2] = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         1'b0, 20'h00008, W + 2};
    vecs[3] = '{1'b1, 32'h0000_0030, 4'hF, 32'h11223344,  1'b1, 20'h0000C, W + 4};
    vecs[4] = '{1'b1, 32'h0000_0030, 4'h2, 32'hAABBCCDD,  1'b0, 20'h0000C, W + 4};
    vecs[5] = '{1'b0, 32'h0000_0030, 4'hF, 32'h0,         1'b1, 20'h0000C, W + 2};
    vecs[6] = '{1'b1, 32'h0000_0040, 4'h0, 32'hCAFEF00D,  1'b1, 20'h00010, W + 4};
    vecs[7] = '{1'b0, 32'h0000_0040, 4'hF, 32'h0,         1'b0, 20'h00010, W + 2};
    vecs[8] = '{1'b0, 32'hFFC0_0020, 4'hF, 32'h0,         1'b0, 20'h00008, W + 2};
    vecs[9] = '{1'b0, 32'h003F_FFFC, 4'hF, 32'h0,         1'b1, 20'hFFFFF, W + 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ce_n", 32'(sram_ce_n_o), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n_o), 32'd1);
    check("rst_we_n", 32'(sram_we_n_o), 32'd1);
    check("rst_be_n", 32'(sram_be_n_o), 32'hF);
    check("rst_ack", 32'(rsp_ack_o), 32'd0);
    check("rst_rdata", rsp_data_o, 32'd0);
    check("rst_addr", 32'(sram_addr_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Back-to-back read/write/read with request held
    b2b[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        1'b1, 20'h00004, W + 2};
    b2b[1] = '{1'b1, 32'h0000_0060, 4'hF, 32'h5A5A1234, 1'b1, 20'h00018, W + 4};
    b2b[2] = '{1'b0, 32'h0000_0060, 4'hF, 32'h0,        1'b1, 20'h00018, W + 2};
    for (int i = 0; i < 3; i++) push_expect(b2b[i].we, b2b[i].addr, b2b[i].sel, b2b[i].data);
    @(negedge clk);
    req_ce_i = 1'b1; req_we_i = b2b[0].we; req_addr_i = b2b[0].addr;
    req_sel_i = b2b[0].sel; req_data_i = b2b[0].data;
    cyc = 0; acks = 0; last_ack = 0; gap_bad = 0; stall_bad = 0; ovl = 0; prev_ce_n = 1'b1;
    while (acks < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (stall_o !== !rsp_ack_o) stall_bad++;
      if ((dbg_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD}) && !sram_oe_n_o) ovl++;
      if (prev_ce_n && !sram_ce_n_o && acks > 0 && (cyc - last_ack) != 2) gap_bad++;
      prev_ce_n = sram_ce_n_o;
      if (rsp_ack_o) begin
        acks++;
        last_ack = cyc;
        if (acks < 3) begin
          req_we_i = b2b[acks].we; req_addr_i = b2b[acks].addr;
          req_sel_i = b2b[acks].sel; req_data_i = b2b[acks].data;
        end else begin
          req_ce_i = 1'b0;
        end
      end
    end
    req_ce_i = 1'b0;
    check("b2b_acks", 32'(acks), 32'd3);
    check("b2b_total_cycles", 32'(cyc), 32'((W + 2) + 1 + (W + 4) + 1 + (W + 2)));
    check("b2b_stall", 32'(stall_bad), 32'd0);
    check("b2b_idle_gap", 32'(gap_bad), 32'd0);
    check("b2b_oe_drive_overlap", 32'(ovl), 32'd0);

    // Reset during write pulse: abort, no ack, no retry
    @(negedge clk);
    req_ce_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0000_0050;
    req_sel_i = 4'hF; req_data_i = 32'h0BADF00D;
    @(posedge clk);
    #1;
    req_ce_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sram_we_n_o && n < 20);
    check("rstwr_pulse_seen", 32'(sram_we_n_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstwr_we_n", 32'(sram_we_n_o), 32'd1);
    check("rstwr_ce_n", 32'(sram_ce_n_o), 32'd1);
    check("rstwr_oe_n", 32'(sram_oe_n_o), 32'd1);
    check("rstwr_be_n", 32'(sram_be_n_o), 32'hF);
    check("rstwr_ack", 32'(rsp_ack_o), 32'd0);
    check("rstwr_rdata", rsp_data_o, 32'd0);
    check("rstwr_addr", 32'(sram_addr_o), 32'd0);
    check("rstwr_state_idle", 32'(dbg_state), 32'(S_IDLE));
    exp_last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    we_lo = 0; ce_lo = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!sram_we_n_o) we_lo++;
      if (!sram_ce_n_o) ce_lo++;
    end
    check("rstwr_no_retry_we", 32'(we_lo), 32'd0);
    check("rstwr_no_retry_ce", 32'(ce_lo), 32'd0);
    run_txn('{1'b0, 32'h0000_0050, 4'hF, 32'h0, 1'b0, 20'h00014, W + 2});

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra cycles (0..7) added to each SRAM read-sample / write-pulse window.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_ce_i  input  1  CPU bus request valid.
REQ-005 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-006 SHALL have port req_addr_i  input  32  byte address; bits [21:2] used, others ignored (aliased).
REQ-007 SHALL have port req_sel_i  input  4  byte select, bit n = byte lane n.
REQ-008 SHALL have port req_data_i  input  32  write data.
REQ-009 SHALL have port rsp_data_o  output  32  read data, valid while rsp_ack_o.
REQ-010 SHALL have port rsp_ack_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port stall_o  output  1  pipeline stall request to CPU.
REQ-012 SHALL have ports sram_addr_o (output 20, word address), sram_data_io (inout 32, SRAM data bus), sram_be_n_o (output 4), sram_ce_n_o, sram_oe_n_o, sram_we_n_o (output 1 each, active-low strobes).

Function
REQ-013 SHALL implement FSM states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-014 SHALL accept a request only in IDLE with req_ce_i=1, latching addr, we, sel, data; later changes of req_* ignored until DONE.
REQ-015 SHALL register all sram_* strobes, address and bus-enable (no combinational path from req_* to SRAM pins).
REQ-016 Read: IDLE->RD; ce_n=0, oe_n=0, we_n=1 for WAIT_CYCLES+1 cycles; data sampled on last RD edge; RD->DONE.
REQ-017 Write: IDLE->WR_SETUP (1 cycle, ce_n=0, we_n=1, bus driven) ->WR_PULSE (WAIT_CYCLES+1 cycles, we_n=0) ->WR_HOLD (1 cycle, we_n=1, bus still driven) ->DONE.
REQ-018 sram_data_io SHALL be driven only in WR_SETUP/WR_PULSE/WR_HOLD, else high-Z; oe_n SHALL be 1 whenever the bus is driven.
REQ-019 DONE SHALL last exactly 1 cycle with rsp_ack_o=1, ce_n=1, oe_n=1; DONE->IDLE unconditionally (one idle cycle between back-to-back requests).
REQ-020 stall_o SHALL equal req_ce_i AND NOT (state==DONE) (combinational).
REQ-021 rsp_data_o SHALL hold last read word until next read completes; write acks leave it unchanged.
REQ-022 Read latency request-accept to ack SHALL be WAIT_CYCLES+2 cycles; write latency WAIT_CYCLES+4.
REQ-023 req_ce_i dropped mid-transaction SHALL NOT abort it; ack still issued.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, ce_n=oe_n=we_n=1, be_n=4'hF, bus high-Z, rsp_ack_o=0, rsp_data_o=0, sram_addr_o=0, regardless of transaction in progress.
REQ-025 An interrupted write SHALL not be retried after reset release.

Configuration
REQ-026 Macro SRAM_CTRL_BYTE_EN: defined -> sram_be_n_o = ~latched sel during writes, 4'h0 during reads; sel=0 write runs full cycle, writes no byte.
REQ-027 Undefined -> sram_be_n_o fixed 4'h0 outside reset; writes always full-word regardless of sel.

Structure
REQ-028 Shared package SHALL hold FSM state encoding, SRAM address width (20) and data width (32) constants.
REQ-029 Single module; tristate buffer kept inline, no sub-module.

Verification
REQ-030 WAIT_CYCLES=1, read addr 0x0000_0010, SRAM model word 0xDEADBEEF -> sram_addr_o=0x00004, ack on 3rd cycle after accept, rsp_data_o=0xDEADBEEF.
REQ-031 Write 0x12345678 to 0x0000_0020, sel=4'hF -> we_n low exactly 2 cycles, bus driven 4 cycles, ack after 5; readback 0x12345678.
REQ-032 With SRAM_CTRL_BYTE_EN, write 0xAABBCCDD sel=4'b0010 over 0x11223344 -> readback 0x1122CC44; without macro -> 0xAABBCCDD.
REQ-033 Back-to-back read/write with req_ce_i held -> stall_o low only in DONE cycles, one IDLE gap between transactions, no cycle with oe_n=0 and bus driven.
REQ-034 rst_n pulsed low mid-WR_PULSE -> same-cycle we_n=1, bus high-Z, no ack; after release next request served normally.
